// File: rtl/sys_debug_ocimem_pkg.sv
// Shared types and defaults for the debug OCI RAM arbiter.
package sys_debug_ocimem_pkg;

   localparam int ADDR_W_DEF   = 8;
   localparam int LOCK_MAX_DEF = 16;

   // Requester index order used by the round-robin picker.
   localparam int REQ_J = 0;
   localparam int REQ_C = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT_J = 2'd1,
      ST_GNT_C = 2'd2
   } state_t;

endpackage

// File: rtl/sys_debug_rr2.sv
// Two-way round-robin picker; req[0] is favoured until the first grant is taken.
module sys_debug_rr2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic favour_1;

   always_comb begin
      gnt = 2'b00;
      if (req[0] && (!req[1] || !favour_1)) begin
         gnt = 2'b01;
      end else if (req[1]) begin
         gnt = 2'b10;
      end
   end

   // After a grant, the other side gets priority on the next tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         favour_1 <= 1'b0;
      end else if (advance && (gnt != 2'b00)) begin
         favour_1 <= gnt[0];
      end
   end

endmodule

// File: rtl/sys_debug_ocimem_arbiter.sv
// Arbitrates the OCI RAM port between the JTAG debug path and the CPU debug slave.
//   state    | meaning
//   ST_IDLE  | no access; arbitrate pending requests
//   ST_GNT_J | JTAG access on the RAM port this cycle
//   ST_GNT_C | CPU access on the RAM port this cycle
module sys_debug_ocimem_arbiter
   import sys_debug_ocimem_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int LOCK_MAX = LOCK_MAX_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              j_req,
   input  logic              j_wr,
   input  logic              j_lock,
   input  logic [ADDR_W-1:0] j_addr,
   input  logic [31:0]       j_wdata,
   output logic              j_gnt,
   output logic              j_rvalid,
   output logic [31:0]       j_rdata,
   input  logic              c_read,
   input  logic              c_write,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [31:0]       c_wdata,
   input  logic [3:0]        c_be,
   output logic              c_waitrequest,
   output logic              c_readdatavalid,
   output logic [31:0]       c_readdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [3:0]        ram_be,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   state_t           state, state_nxt;
   logic [1:0]       arb_req, arb_gnt;
   logic             arb_adv;
   logic [CNT_W-1:0] lock_cnt;
   logic             lock_done;
   logic             rd_j_p1, rd_c_p1;

   assign arb_req[REQ_J] = j_req;
   assign arb_req[REQ_C] = c_read | c_write;
   assign arb_adv        = (state == ST_IDLE);
   assign lock_done      = (lock_cnt == CNT_W'(LOCK_MAX - 1));

   sys_debug_rr2 u_rr2 (
      .clk     (clk),
      .reset   (reset),
      .req     (arb_req),
      .advance (arb_adv),
      .gnt     (arb_gnt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (arb_gnt[REQ_J]) begin
               state_nxt = ST_GNT_J;
            end else if (arb_gnt[REQ_C]) begin
               state_nxt = ST_GNT_C;
            end
         end
         ST_GNT_J: state_nxt = (j_lock && j_req && !lock_done) ? ST_GNT_J : ST_IDLE;
         ST_GNT_C: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      j_gnt         = 1'b0;
      c_waitrequest = 1'b1;
      ram_addr      = '0;
      ram_wren      = 1'b0;
      ram_be        = 4'h0;
      ram_wdata     = 32'h0;
      case (state)
         ST_GNT_J: begin
            j_gnt     = 1'b1;
            ram_addr  = j_addr;
            ram_wren  = j_wr;
            ram_be    = 4'hF;
            ram_wdata = j_wdata;
         end
         ST_GNT_C: begin
            c_waitrequest = 1'b0;
            ram_addr      = c_addr;
            ram_wren      = c_write;
            ram_be        = c_be;
            ram_wdata     = c_wdata;
         end
         default: ;
      endcase
   end

   // Read return: RAM data valid the cycle after the grant, registered out one cycle later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_cnt        <= '0;
         rd_j_p1         <= 1'b0;
         rd_c_p1         <= 1'b0;
         j_rvalid        <= 1'b0;
         j_rdata         <= 32'h0;
         c_readdatavalid <= 1'b0;
         c_readdata      <= 32'h0;
      end else begin
         lock_cnt        <= (state == ST_GNT_J) ? lock_cnt + 1'b1 : '0;
         rd_j_p1         <= (state == ST_GNT_J) && !j_wr;
         rd_c_p1         <= (state == ST_GNT_C) && c_read && !c_write;
         j_rvalid        <= rd_j_p1;
         c_readdatavalid <= rd_c_p1;
         if (rd_j_p1) begin
            j_rdata <= ram_rdata;
         end
         if (rd_c_p1) begin
            c_readdata <= ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_sys_debug_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter with a byte-enable RAM model on the RAM port.
module tb_sys_debug_ocimem_arbiter;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          j_req, j_wr, j_lock;
   logic [AW-1:0] j_addr;
   logic [31:0]   j_wdata;
   logic          j_gnt, j_rvalid;
   logic [31:0]   j_rdata;
   logic          c_read, c_write;
   logic [AW-1:0] c_addr;
   logic [31:0]   c_wdata;
   logic [3:0]    c_be;
   logic          c_waitrequest, c_readdatavalid;
   logic [31:0]   c_readdata;
   logic [AW-1:0] ram_addr;
   logic          ram_wren;
   logic [3:0]    ram_be;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sys_debug_ocimem_arbiter #(.ADDR_W(AW), .LOCK_MAX(16)) dut (
      .clk             (clk),
      .reset           (reset),
      .j_req           (j_req),
      .j_wr            (j_wr),
      .j_lock          (j_lock),
      .j_addr          (j_addr),
      .j_wdata         (j_wdata),
      .j_gnt           (j_gnt),
      .j_rvalid        (j_rvalid),
      .j_rdata         (j_rdata),
      .c_read          (c_read),
      .c_write         (c_write),
      .c_addr          (c_addr),
      .c_wdata         (c_wdata),
      .c_be            (c_be),
      .c_waitrequest   (c_waitrequest),
      .c_readdatavalid (c_readdatavalid),
      .c_readdata      (c_readdata),
      .ram_addr        (ram_addr),
      .ram_wren        (ram_wren),
      .ram_be          (ram_be),
      .ram_wdata       (ram_wdata),
      .ram_rdata       (ram_rdata)
   );

   // RAM model: word i holds 0xC00000ii after reset, except word 5 which holds 0.
   logic [31:0] mem [0:255];
   logic [31:0] merged;

   always_comb begin
      merged = mem[ram_addr];
      for (int b = 0; b < 4; b++) begin
         if (ram_be[b]) merged[8*b +: 8] = ram_wdata[8*b +: 8];
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) begin
            mem[i] <= (i == 5) ? 32'h0 : (32'hC000_0000 | 32'(i));
         end
         ram_rdata <= 32'h0;
      end else begin
         if (ram_wren) mem[ram_addr] <= merged;
         ram_rdata <= mem[ram_addr];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_j_gnt"}, 32'(j_gnt), 32'h0);
      check({tag, "_j_rvalid"}, 32'(j_rvalid), 32'h0);
      check({tag, "_j_rdata"}, j_rdata, 32'h0);
      check({tag, "_c_waitrequest"}, 32'(c_waitrequest), 32'h1);
      check({tag, "_c_readdatavalid"}, 32'(c_readdatavalid), 32'h0);
      check({tag, "_c_readdata"}, c_readdata, 32'h0);
      check({tag, "_ram_wren"}, 32'(ram_wren), 32'h0);
      check({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
      check({tag, "_ram_be"}, 32'(ram_be), 32'h0);
      check({tag, "_ram_wdata"}, ram_wdata, 32'h0);
   endtask

   initial begin
      int       k, rcnt, ccnt;
      logic     prev_jg, prev_cg;
      logic [1:0] exp_g;

      reset = 1'b1;
      j_req = 0; j_wr = 0; j_lock = 0; j_addr = '0; j_wdata = '0;
      c_read = 0; c_write = 0; c_addr = '0; c_wdata = '0; c_be = 4'h0;

      repeat (3) step();
      check_reset_values("rst");
      reset = 1'b0;
      step();

      // Simultaneous reads after reset: JTAG first, then CPU.
      j_req = 1; j_wr = 0; j_addr = 8'h10;
      c_read = 1; c_addr = 8'h20; c_be = 4'hF;
      #1;
      check("tie_idle_wait", 32'(c_waitrequest), 32'h1);
      check("tie_idle_jgnt", 32'(j_gnt), 32'h0);
      step();
      check("tie_jgnt", 32'(j_gnt), 32'h1);
      check("tie_j_addr", 32'(ram_addr), 32'h10);
      check("tie_j_be", 32'(ram_be), 32'hF);
      check("tie_j_wren", 32'(ram_wren), 32'h0);
      check("tie_c_wait", 32'(c_waitrequest), 32'h1);
      step();
      j_req = 0;
      #1;
      check("tie_idle2_wait", 32'(c_waitrequest), 32'h1);
      check("tie_idle2_rvalid", 32'(j_rvalid), 32'h0);
      step();
      check("tie_cgnt", 32'(c_waitrequest), 32'h0);
      check("tie_c_addr", 32'(ram_addr), 32'h20);
      check("tie_j_rvalid", 32'(j_rvalid), 32'h1);
      check("tie_j_rdata", j_rdata, 32'hC000_0010);
      check("tie_c_rdv_early", 32'(c_readdatavalid), 32'h0);
      step();
      c_read = 0;
      #1;
      check("tie_j_rvalid_pulse", 32'(j_rvalid), 32'h0);
      step();
      check("tie_c_rdv", 32'(c_readdatavalid), 32'h1);
      check("tie_c_rdata", c_readdata, 32'hC000_0020);
      check("tie_j_no_rvalid", 32'(j_rvalid), 32'h0);
      step();
      check("tie_c_rdv_pulse", 32'(c_readdatavalid), 32'h0);

      // CPU partial write then readback.
      c_write = 1; c_addr = 8'h05; c_wdata = 32'hDEAD_BEEF; c_be = 4'b0011;
      step();
      check("bw_wren", 32'(ram_wren), 32'h1);
      check("bw_be", 32'(ram_be), 32'h3);
      check("bw_addr", 32'(ram_addr), 32'h05);
      check("bw_wdata", ram_wdata, 32'hDEAD_BEEF);
      step();
      c_write = 0;
      #1;
      check("bw_single_wren", 32'(ram_wren), 32'h0);
      c_read = 1; c_be = 4'hF;
      step();
      check("bw_rd_gnt", 32'(c_waitrequest), 32'h0);
      step();
      c_read = 0;
      step();
      check("bw_rdv", 32'(c_readdatavalid), 32'h1);
      check("bw_rdata", c_readdata, 32'h0000_BEEF);

      // Read and write strobes together behave as a write.
      c_read = 1; c_write = 1; c_addr = 8'h01; c_wdata = 32'h1234_5678; c_be = 4'hF;
      step();
      check("rw_wren", 32'(ram_wren), 32'h1);
      check("rw_addr", 32'(ram_addr), 32'h01);
      step();
      c_read = 0; c_write = 0;
      #1;
      check("rw_no_rdv1", 32'(c_readdatavalid), 32'h0);
      step();
      check("rw_no_rdv2", 32'(c_readdatavalid), 32'h0);
      step();
      check("rw_no_rdv3", 32'(c_readdatavalid), 32'h0);
      j_req = 1; j_wr = 0; j_addr = 8'h01;
      step();
      check("rw_j_gnt", 32'(j_gnt), 32'h1);
      step();
      j_req = 0;
      step();
      check("rw_j_rvalid", 32'(j_rvalid), 32'h1);
      check("rw_j_rdata", j_rdata, 32'h1234_5678);
      step();

      // Locked 20-read JTAG burst with the CPU waiting from the first cycle.
      j_req = 1; j_wr = 0; j_lock = 1; j_addr = 8'h40;
      k = 0; rcnt = 0; ccnt = 0; prev_jg = 0; prev_cg = 0;
      for (int i = 0; i < 26; i++) begin
         step();
         if (prev_jg) begin
            k++;
            j_addr = 8'h40 + 8'(k);
            j_lock = (k < 19);
            j_req  = (k < 20);
         end
         if (i == 0) begin
            c_read = 1; c_addr = 8'h30; c_be = 4'hF;
         end
         if (prev_cg) c_read = 0;
         #1;
         exp_g = (i < 16 || (i >= 19 && i <= 22)) ? 2'b10 : (i == 17) ? 2'b01 : 2'b00;
         check($sformatf("burst_gnt_%0d", i), 32'({j_gnt, ~c_waitrequest}), 32'(exp_g));
         if (j_rvalid) begin
            check($sformatf("burst_rdata_%0d", rcnt), j_rdata, 32'hC000_0040 + 32'(rcnt));
            rcnt++;
         end
         if (c_readdatavalid) begin
            check("burst_cpu_rdata", c_readdata, 32'hC000_0030);
            ccnt++;
         end
         prev_jg = j_gnt;
         prev_cg = ~c_waitrequest;
      end
      check("burst_rvalid_count", 32'(rcnt), 32'd20);
      check("burst_cpu_rdv_count", 32'(ccnt), 32'd1);

      // Both sides requesting continuously: grants alternate, CPU first.
      j_req = 1; j_wr = 0; j_lock = 0; j_addr = 8'h11;
      c_read = 1; c_write = 0; c_addr = 8'h22; c_be = 4'hF;
      for (int i = 0; i < 100; i++) begin
         step();
         exp_g = (i % 2 == 1) ? 2'b00 : (((i / 2) % 2 == 0) ? 2'b01 : 2'b10);
         check($sformatf("alt_gnt_%0d", i), 32'({j_gnt, ~c_waitrequest}), 32'(exp_g));
      end
      j_req = 0; c_read = 0;
      repeat (4) step();

      // Reset in the cycle after a JTAG read grant discards the response.
      j_req = 1; j_wr = 0; j_addr = 8'h10;
      step();
      check("mid_j_gnt", 32'(j_gnt), 32'h1);
      step();
      j_req = 0;
      reset = 1'b1;
      #1;
      check_reset_values("mid");
      step();
      check("mid_rvalid_in_reset", 32'(j_rvalid), 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("mid_no_rvalid_%0d", i), 32'(j_rvalid), 32'h0);
         check($sformatf("mid_rdata_%0d", i), j_rdata, 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
